// File: rtl/tb_err_collector.sv
// rtl/tb_err_collector.sv - sticky error flags with per-index counters and a record-stream report scanner
// Collection runs every cycle; a report walks a snapshot of the flags and emits (index, count) records.
module tb_err_collector #(
  parameter int NUM_ERR = 32,
  parameter int COUNT_W = 8,
  localparam int IDX_W = $clog2(NUM_ERR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_ERR-1:0] err_set,
  input  logic               clear,
  input  logic               report_req,
  input  logic               rep_ready,
  output logic [NUM_ERR-1:0] err_flags,
  output logic               err_any,
  output logic               busy,
  output logic               rep_valid,
  output logic [IDX_W-1:0]   rep_index,
  output logic [COUNT_W-1:0] rep_count,
  output logic               rep_done
);

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ERR - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_ERR-1:0] snap_mask;
  logic [COUNT_W-1:0] cnt [NUM_ERR];

  assign err_any = |err_flags;

  // A set pulse beats a simultaneous clear, so the count restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      for (int i = 0; i < NUM_ERR; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ERR; i++) begin
        if (err_set[i]) begin
          err_flags[i] <= 1'b1;
          if (clear)
            cnt[i] <= COUNT_W'(1);
          else if (cnt[i] != CNT_MAX)
            cnt[i] <= cnt[i] + 1'b1;
        end else if (clear) begin
          err_flags[i] <= 1'b0;
          cnt[i]       <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      snap_mask <= '0;
      busy      <= 1'b0;
      rep_valid <= 1'b0;
      rep_index <= '0;
      rep_count <= '0;
      rep_done  <= 1'b0;
    end else begin
      rep_done <= 1'b0;
      if (clear) begin
        // Abort: the held record is dropped and no completion pulse is produced.
        state     <= IDLE;
        rep_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (report_req) begin
              snap_mask <= err_flags;
              ptr       <= '0;
              busy      <= 1'b1;
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (snap_mask[ptr]) begin
              rep_index <= ptr;
              rep_count <= cnt[ptr];
              rep_valid <= 1'b1;
              state     <= EMIT;
            end else if (ptr == LAST_IDX) begin
              busy     <= 1'b0;
              rep_done <= 1'b1;
              state    <= DONE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          EMIT: begin
            if (rep_ready) begin
              rep_valid <= 1'b0;
              if (ptr == LAST_IDX) begin
                busy     <= 1'b0;
                rep_done <= 1'b1;
                state    <= DONE;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= SCAN;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tb_err_collector.sv
// tb/tb_tb_err_collector.sv - directed bench for the error collector and its report stream
module tb_tb_err_collector;

  logic        clk;
  logic        reset;
  logic [31:0] err_set;
  logic        clear;
  logic        report_req;
  logic        rep_ready;
  logic [31:0] err_flags;
  logic        err_any;
  logic        busy;
  logic        rep_valid;
  logic [4:0]  rep_index;
  logic [7:0]  rep_count;
  logic        rep_done;

  int checks = 0;
  int errors = 0;

  int idx_q[$];
  int cnt_q[$];
  int valid_at;
  int done_at;
  int done_cnt;
  int cyc;

  tb_err_collector dut (
    .clk        (clk),
    .reset      (reset),
    .err_set    (err_set),
    .clear      (clear),
    .report_req (report_req),
    .rep_ready  (rep_ready),
    .err_flags  (err_flags),
    .err_any    (err_any),
    .busy       (busy),
    .rep_valid  (rep_valid),
    .rep_index  (rep_index),
    .rep_count  (rep_count),
    .rep_done   (rep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] v);
    err_set = v;
    tick();
    err_set = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that samples report_req.
  task automatic run_report(input int budget);
    idx_q.delete();
    cnt_q.delete();
    valid_at = -1;
    done_at  = -1;
    done_cnt = 0;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      if (rep_valid && rep_ready) begin
        idx_q.push_back(int'(rep_index));
        cnt_q.push_back(int'(rep_count));
        if (valid_at < 0) valid_at = cyc;
      end
      if (rep_done) begin
        done_cnt++;
        done_at = cyc;
        break;
      end
      tick();
      cyc++;
    end
    chk("report_done_seen", 64'(done_at >= 0), 64'd1);
    tick();
    chk("rep_done_one_cycle", 64'(rep_done), 64'd0);
  endtask

  initial begin
    int n;
    logic stable;

    reset      = 1'b1;
    err_set    = '0;
    clear      = 1'b0;
    report_req = 1'b0;
    rep_ready  = 1'b0;
    #12;
    chk("reset_flags", 64'(err_flags), 64'd0);
    chk("reset_any",   64'(err_any),   64'd0);
    chk("reset_busy",  64'(busy),      64'd0);
    chk("reset_valid", 64'(rep_valid), 64'd0);
    chk("reset_index", 64'(rep_index), 64'd0);
    chk("reset_count", 64'(rep_count), 64'd0);
    chk("reset_done",  64'(rep_done),  64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Empty snapshot: completion at cycle 33 with no records.
    rep_ready = 1'b1;
    run_report(60);
    chk("empty_done_cycle", 64'(done_at), 64'd33);
    chk("empty_records", 64'(idx_q.size()), 64'd0);
    chk("empty_err_any", 64'(err_any), 64'd0);
    chk("empty_busy_after", 64'(busy), 64'd0);

    // Two flagged indices with counts.
    pulse(32'h0000_0010);
    pulse(32'h0000_2010);
    pulse(32'h0000_0010);
    chk("flags_4_13", 64'(err_flags), 64'h2010);
    chk("any_4_13", 64'(err_any), 64'd1);
    run_report(60);
    chk("two_rec_count", 64'(idx_q.size()), 64'd2);
    if (idx_q.size() == 2) begin
      chk("rec0_index", 64'(idx_q[0]), 64'd4);
      chk("rec0_count", 64'(cnt_q[0]), 64'd3);
      chk("rec1_index", 64'(idx_q[1]), 64'd13);
      chk("rec1_count", 64'(cnt_q[1]), 64'd1);
    end
    chk("two_rec_done_cycle", 64'(done_at), 64'd35);

    // Saturation.
    do_clear();
    chk("clear_flags", 64'(err_flags), 64'd0);
    err_set = 32'h0001_0000;
    for (int i = 0; i < 300; i++) tick();
    err_set = '0;
    chk("sat_flags", 64'(err_flags), 64'h1_0000);
    run_report(60);
    chk("sat_rec_size", 64'(idx_q.size()), 64'd1);
    if (idx_q.size() == 1) begin
      chk("sat_index", 64'(idx_q[0]), 64'd16);
      chk("sat_count", 64'(cnt_q[0]), 64'd255);
    end

    // Back-pressure: the held record must not move while new counts arrive.
    do_clear();
    pulse(32'h0000_0100);
    rep_ready  = 1'b0;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    n = 0;
    while (!rep_valid && n < 60) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", 64'(rep_valid), 64'd1);
    chk("bp_index", 64'(rep_index), 64'd8);
    chk("bp_count", 64'(rep_count), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      err_set = (i == 2 || i == 5) ? 32'h0000_0100 : 32'h0;
      tick();
      if (!(rep_valid === 1'b1 && rep_index === 5'd8 && rep_count === 8'd1 && busy === 1'b1))
        stable = 1'b0;
    end
    err_set = '0;
    chk("bp_stable", 64'(stable), 64'd1);
    rep_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 64'(rep_valid), 64'd0);
    n = 0;
    while (!rep_done && n < 60) begin
      tick();
      n++;
    end
    chk("bp_done_seen", 64'(rep_done), 64'd1);
    tick();
    run_report(60);
    chk("bp_rerun_size", 64'(idx_q.size()), 64'd1);
    if (idx_q.size() == 1) begin
      chk("bp_rerun_index", 64'(idx_q[0]), 64'd8);
      chk("bp_rerun_count", 64'(cnt_q[0]), 64'd3);
    end

    // Abort mid-report.
    do_clear();
    pulse(32'h0008_0001);
    rep_ready  = 1'b0;
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
    n = 0;
    while (!rep_valid && n < 60) begin
      tick();
      n++;
    end
    chk("abort_valid_seen", 64'(rep_valid), 64'd1);
    chk("abort_index", 64'(rep_index), 64'd0);
    chk("abort_count", 64'(rep_count), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_valid", 64'(rep_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(rep_done), 64'd0);
    chk("abort_flags", 64'(err_flags), 64'd0);
    rep_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rep_done || rep_valid || busy) n++;
    end
    chk("abort_quiet", 64'(n), 64'd0);

    // Set beats clear; last index emits then finishes without an extra scan cycle.
    pulse(32'h0000_0004);
    clear   = 1'b1;
    err_set = 32'h8000_0000;
    tick();
    clear   = 1'b0;
    err_set = '0;
    chk("setwins_flags", 64'(err_flags), 64'h8000_0000);
    run_report(60);
    chk("last_rec_size", 64'(idx_q.size()), 64'd1);
    if (idx_q.size() == 1) begin
      chk("last_index", 64'(idx_q[0]), 64'd31);
      chk("last_count", 64'(cnt_q[0]), 64'd1);
    end
    chk("last_valid_cycle", 64'(valid_at), 64'd33);
    chk("last_done_cycle", 64'(done_at), 64'd34);
    chk("last_hold_index", 64'(rep_index), 64'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_err_collector.md
Name: tb_err_collector

Overview:
- Verification-side collector for the testbench error vector, whose bit positions are the package error indices: 0–4 clock/phase checks, 8–14 op-code readbacks, 16–19 test IDs.
- Checkers write error pulses into this block; it is the reader side.
- It latches sticky flags and counts occurrences per index.
- On request it scans the vector and emits one (index, count) record per flagged index over a valid/ready stream, for the end-of-test report and the scoreboard.

Parameters:
- NUM_ERR, 32, number of error indices; valid indices are 0..NUM_ERR-1.
- COUNT_W, 8, width of each per-index saturating occurrence counter.
- IDX_W, $clog2(NUM_ERR), width of rep_index (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- err_set  in  NUM_ERR  one-cycle error pulses from checkers; bit i corresponds to error index i.
- clear  in  1  synchronous clear of flags and counters; aborts any report in progress.
- report_req  in  1  pulse that starts a report scan; ignored while busy=1.
- rep_ready  in  1  consumer ready for the record stream.
- err_flags  out  NUM_ERR  sticky error flags (registered).
- err_any  out  1  OR of err_flags (combinational from the register).
- busy  out  1  high while in SCAN or EMIT.
- rep_valid  out  1  record valid.
- rep_index  out  IDX_W  error index of the current record.
- rep_count  out  COUNT_W  occurrence count of the current record.
- rep_done  out  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Reset (asynchronous) sets all of the following to 0: err_flags, all counters, rep_valid, rep_index, rep_count, busy, rep_done. FSM goes to IDLE.
- Collection runs every cycle, in every FSM state.
  - err_set[i]=1 sets err_flags[i]=1, visible the next cycle.
  - err_set[i]=1 also increments cnt[i], saturating at 2^COUNT_W-1 (no wrap).
  - Multiple bits in one cycle each count once.
- clear: flags and counters become 0 next cycle.
  - clear and err_set[i] in the same cycle: set wins; next cycle err_flags[i]=1 and cnt[i]=1.
  - Other bits clear as normal.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE: busy=0.
  - report_req=1 (and clear=0) copies err_flags into snap_mask, sets ptr=0, and moves to SCAN.
  - report_req and clear in the same cycle: clear wins and the request is dropped.
- SCAN: one index per cycle, ptr = 0..NUM_ERR-1.
  - snap_mask[ptr]=1: load rep_index=ptr and rep_count=cnt[ptr] (value at that edge), assert rep_valid, go to EMIT.
  - Otherwise advance ptr.
  - After ptr=NUM_ERR-1 is checked and not emitted, go to DONE.
- EMIT: rep_valid, rep_index and rep_count are held stable until rep_valid & rep_ready.
  - On the handshake: rep_valid drops, ptr increments, and the FSM returns to SCAN.
  - If ptr was NUM_ERR-1, the FSM goes to DONE instead.
  - Counts arriving during EMIT do not alter the held record.
- DONE: rep_done=1 for exactly one cycle, then IDLE. rep_index and rep_count keep their last values.
- Snapshot semantics: flags that set after report_req are not reported in the current scan, but are still collected.
- clear in SCAN, EMIT or DONE aborts the scan.
  - Next cycle: FSM in IDLE, rep_valid=0, busy=0, and no rep_done pulse.
- Latency, empty snapshot: report_req at cycle 0 gives rep_done at cycle NUM_ERR+1.
  - Each flagged index adds 1 cycle plus the rep_ready wait.
- rep_ready held at 1: one record every 2 cycles minimum.
- rep_ready while rep_valid=0 has no effect.
- Index NUM_ERR-1 flagged: its record is emitted, then DONE with no extra SCAN cycle.

Test Plan:
- Reset then idle, report_req at cycle 0 with no errors → no rep_valid, rep_done at cycle 33, err_any=0.
- Pulse err_set[4] three times and err_set[13] once, then report_req with rep_ready=1 → records (4,3) then (13,1), then rep_done; err_flags=32'h0000_2010.
- Pulse err_set[16] 300 times (COUNT_W=8) → report record (16,255); counter does not wrap.
- Flag index 8, hold rep_ready=0 for 10 cycles during EMIT while pulsing err_set[8] twice → record stays stable at (8,1) until the handshake; a subsequent report shows (8,3).
- Flag indices 0 and 19, report_req, assert clear while record (0,n) is pending → next cycle rep_valid=0, busy=0, no rep_done, err_flags=0.
- Same cycle clear and err_set[31]=1 → err_flags=32'h8000_0000, cnt[31]=1; report emits (31,1) then rep_done with no extra SCAN cycle.
